// File: rtl/image_sdram_rr_arbiter_if.sv
// image_sdram_rr_arbiter_if: Avalon-MM bundle between N image cores, the arbiter and the SDRAM controller
interface image_sdram_rr_arbiter_if #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16
);
    localparam int BE_W = DATA_W / 8;
    logic [N_MASTERS*ADDR_W-1:0] m_address;
    logic [N_MASTERS-1:0]        m_read;
    logic [N_MASTERS-1:0]        m_write;
    logic [N_MASTERS*DATA_W-1:0] m_writedata;
    logic [N_MASTERS*BE_W-1:0]   m_byteenable;
    logic [N_MASTERS-1:0]        m_waitrequest;
    logic [DATA_W-1:0]           m_readdata;
    logic [N_MASTERS-1:0]        m_readdatavalid;
    logic [ADDR_W-1:0]           s_address;
    logic                        s_read;
    logic                        s_write;
    logic [DATA_W-1:0]           s_writedata;
    logic [BE_W-1:0]             s_byteenable;
    logic                        s_waitrequest;
    logic [DATA_W-1:0]           s_readdata;
    logic                        s_readdatavalid;
    modport slave (
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );
    modport master (
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid
    );
endinterface

// File: rtl/image_sdram_rr_arbiter.sv
// image_sdram_rr_arbiter: round-robin N-master Avalon-MM arbiter with a read-tag return FIFO
module image_sdram_rr_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    image_sdram_rr_arbiter_if.slave       bus,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          err_orphan
);
    localparam int ID_W = $clog2(N_MASTERS);
    localparam int PW   = $clog2(MAX_PENDING);
    localparam int BE_W = DATA_W / 8;
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t               state, state_nx;
    logic [ID_W-1:0]      ptr, locked_id, sel, g, head;
    logic [ID_W-1:0]      fifo [MAX_PENDING];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [N_MASTERS-1:0] req;
    logic                 found, full, empty, rd_g, wr_g, cmd, accept, push, pop;

    assign full           = pending_count == (PW+1)'(MAX_PENDING);
    assign empty          = pending_count == '0;
    assign req            = bus.m_write | (bus.m_read & ~{N_MASTERS{full}});
    assign head           = fifo[rd_ptr];
    assign bus.m_readdata = bus.s_readdata;

    // round-robin search: lowest requester at or above ptr, otherwise lowest overall (wrap)
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) if (req[k]) begin found = 1'b1; sel = ID_W'(k); end
        for (int k = N_MASTERS - 1; k >= 0; k--) if (req[k] && ID_W'(k) >= ptr) sel = ID_W'(k);
    end

    // grant, forwarding from master g, per-master stall and one-hot read return
    always_comb begin
        g                   = (state == LOCKED) ? locked_id : sel;
        rd_g                = 1'b0;
        wr_g                = 1'b0;
        bus.s_address       = '0;
        bus.s_writedata     = '0;
        bus.s_byteenable    = '0;
        for (int k = 0; k < N_MASTERS; k++) if (ID_W'(k) == g) begin
            rd_g             = bus.m_read[k];
            wr_g             = bus.m_write[k];
            bus.s_address    = bus.m_address[k*ADDR_W +: ADDR_W];
            bus.s_writedata  = bus.m_writedata[k*DATA_W +: DATA_W];
            bus.s_byteenable = bus.m_byteenable[k*BE_W +: BE_W];
        end
        bus.s_write         = ~reset_reset & (found | (state == LOCKED)) & wr_g;
        bus.s_read          = ~reset_reset & (found | (state == LOCKED)) & rd_g & ~wr_g & ~full;
        cmd                 = bus.s_read | bus.s_write;
        accept              = cmd & ~bus.s_waitrequest;
        push                = accept & bus.s_read;
        pop                 = ~reset_reset & bus.s_readdatavalid & ~empty;
        bus.m_waitrequest   = '1;
        bus.m_readdatavalid = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (cmd && ID_W'(k) == g) bus.m_waitrequest[k] = bus.s_waitrequest;
            if (pop && head == ID_W'(k)) bus.m_readdatavalid[k] = 1'b1;
        end
        state_nx            = accept ? UNLOCKED : cmd ? LOCKED : state;
    end

    // lock register: held from a stalled command until it is accepted
    always_ff @(posedge clk_clk) state <= reset_reset ? UNLOCKED : state_nx;

    // round-robin pointer, locked owner, FIFO pointers, outstanding count and sticky orphan flag
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ptr           <= '0;
            locked_id     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending_count <= '0;
            err_orphan    <= 1'b0;
        end else begin
            if (cmd && bus.s_waitrequest) locked_id <= g;
            if (accept) ptr <= (g == ID_W'(N_MASTERS - 1)) ? '0 : g + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            pending_count <= pending_count + (PW+1)'(push) - (PW+1)'(pop);
            if (bus.s_readdatavalid && empty) err_orphan <= 1'b1;
        end
    end

    // tag storage: issuing master id of each accepted read, in issue order
    always_ff @(posedge clk_clk) if (push) fifo[wr_ptr] <= g;
endmodule

// File: tb/tb_image_sdram_rr_arbiter.sv
// tb_image_sdram_rr_arbiter: directed plus randomized checks against a queue-based arbiter model
module tb_image_sdram_rr_arbiter;
    localparam int N = 4, AW = 25, DW = 16, BW = 2, MAXP = 8;
    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [3:0] pending_count;
    logic       err_orphan;
    int n_tests = 0, n_fail = 0;
    int rr = 0, held = 0, held_id = 0, orph = 0;
    int tags[$];

    image_sdram_rr_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    image_sdram_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP)) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .bus(bus),
        .pending_count(pending_count),
        .err_orphan(err_orphan)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(bus.m_address >> (i * AW));
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int i);
        return DW'(bus.m_writedata >> (i * DW));
    endfunction

    function automatic logic [BW-1:0] be_of(input int i);
        return BW'(bus.m_byteenable >> (i * BW));
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        logic [N*AW-1:0] m;
        m = (N*AW)'({AW{1'b1}}) << (i * AW);
        bus.m_address = (bus.m_address & ~m) | ((N*AW)'(a) << (i * AW));
    endtask

    task automatic idle();
        bus.m_read = '0;
        bus.m_write = '0;
        bus.m_address = '0;
        bus.m_writedata = '0;
        bus.m_byteenable = '0;
        bus.s_waitrequest = 1'b0;
        bus.s_readdata = '0;
        bus.s_readdatavalid = 1'b0;
    endtask

    task automatic mid();
        #4;
    endtask

    // compare all outputs with the model for the current cycle, then advance the model over the edge
    task automatic step();
        int q_n = tags.size();
        bit full_m = (q_n == MAXP);
        int g = -1;
        bit e_wr = 1'b0, e_rd = 1'b0;
        logic [N-1:0] e_wait = '1;
        logic [N-1:0] e_rdv = '0;
        if (!reset_reset) begin
            if (held != 0) g = held_id;
            else for (int k = 0; k < N; k++) begin
                int c = (rr + k) % N;
                if (g < 0 && (((bus.m_write >> c) & 1) != 0 || (((bus.m_read >> c) & 1) != 0 && !full_m))) g = c;
            end
        end
        if (g >= 0) begin
            e_wr = ((bus.m_write >> g) & 1) != 0;
            e_rd = ((bus.m_read >> g) & 1) != 0 && !e_wr && !full_m;
        end
        if ((e_wr || e_rd) && !bus.s_waitrequest) e_wait = e_wait & ~(N'(1) << g);
        if (!reset_reset && bus.s_readdatavalid && q_n > 0) e_rdv = N'(1) << tags[0];
        check("s_read", 64'(bus.s_read), 64'(e_rd));
        check("s_write", 64'(bus.s_write), 64'(e_wr));
        check("m_waitrequest", 64'(bus.m_waitrequest), 64'(e_wait));
        check("m_readdatavalid", 64'(bus.m_readdatavalid), 64'(e_rdv));
        check("m_readdata", 64'(bus.m_readdata), 64'(bus.s_readdata));
        check("pending_count", 64'(pending_count), 64'(q_n));
        check("err_orphan", 64'(err_orphan), 64'(orph));
        if (e_wr || e_rd) check("s_address", 64'(bus.s_address), 64'(addr_of(g)));
        if (e_wr) begin
            check("s_writedata", 64'(bus.s_writedata), 64'(wdata_of(g)));
            check("s_byteenable", 64'(bus.s_byteenable), 64'(be_of(g)));
        end
        if (reset_reset) begin
            tags.delete();
            rr = 0;
            held = 0;
            orph = 0;
        end else begin
            if (bus.s_readdatavalid) begin
                if (q_n > 0) void'(tags.pop_front());
                else orph = 1;
            end
            if (e_wr || e_rd) begin
                if (bus.s_waitrequest) begin
                    held = 1;
                    held_id = g;
                end else begin
                    held = 0;
                    rr = (g + 1) % N;
                    if (e_rd) tags.push_back(g);
                end
            end
        end
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_reset = 1'b1;
        mid();
        step();
        reset_reset = 1'b0;
    endtask

    initial begin
        idle();
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        repeat (3) begin
            mid();
            check("rst_wait", 64'(bus.m_waitrequest), 64'hF);
            step();
        end
        reset_reset = 1'b0;
        // single write from master 0, then ptr must favour master 1
        bus.m_write = 4'b0001;
        set_addr(0, 25'h10);
        bus.m_writedata = 32'h0000_A5A5;
        bus.m_byteenable = 8'h03;
        mid();
        check("tp1_s_write", 64'(bus.s_write), 64'd1);
        check("tp1_s_address", 64'(bus.s_address), 64'h10);
        check("tp1_s_writedata", 64'(bus.s_writedata), 64'hA5A5);
        check("tp1_wait", 64'(bus.m_waitrequest), 64'hE);
        step();
        idle();
        mid();
        check("tp1_idle", 64'(bus.s_write), 64'd0);
        step();
        bus.m_write = 4'b0011;
        set_addr(0, 25'h10);
        set_addr(1, 25'h11);
        mid();
        check("tp1_ptr", 64'(bus.s_address), 64'h11);
        step();
        // all four write continuously: strict rotation, one per cycle
        do_reset();
        bus.m_write = 4'b1111;
        for (int i = 0; i < N; i++) set_addr(i, AW'(25'h100 + i));
        for (int c = 0; c < 8; c++) begin
            mid();
            check("tp2_grant", 64'(bus.s_address), 64'(25'h100 + c % 4));
            check("tp2_wr", 64'(bus.s_write), 64'd1);
            step();
        end
        // stalled read from master 2 keeps the lock while master 1 waits
        do_reset();
        set_addr(2, 25'h200);
        set_addr(1, 25'h101);
        bus.m_read = 4'b0100;
        bus.s_waitrequest = 1'b1;
        mid();
        check("tp3_lock0", 64'(bus.s_address), 64'h200);
        step();
        bus.m_write = 4'b0010;
        repeat (2) begin
            mid();
            check("tp3_lock", 64'(bus.s_address), 64'h200);
            check("tp3_m1_wait", 64'(bus.m_waitrequest[1]), 64'd1);
            step();
        end
        bus.s_waitrequest = 1'b0;
        mid();
        check("tp3_accept", 64'(bus.s_address), 64'h200);
        check("tp3_read", 64'(bus.s_read), 64'd1);
        step();
        bus.m_read = 4'b0000;
        mid();
        check("tp3_next", 64'(bus.s_address), 64'h101);
        check("tp3_next_wr", 64'(bus.s_write), 64'd1);
        step();
        // reads from masters 1 then 3 return in order
        do_reset();
        set_addr(1, 25'h300);
        set_addr(3, 25'h303);
        bus.m_read = 4'b0010;
        mid();
        step();
        bus.m_read = 4'b1000;
        mid();
        step();
        bus.m_read = 4'b0000;
        mid();
        check("tp4_pend2", 64'(pending_count), 64'd2);
        step();
        bus.s_readdatavalid = 1'b1;
        bus.s_readdata = 16'h1111;
        mid();
        check("tp4_rdv1", 64'(bus.m_readdatavalid), 64'b0010);
        check("tp4_data1", 64'(bus.m_readdata), 64'h1111);
        step();
        bus.s_readdata = 16'h3333;
        mid();
        check("tp4_pend1", 64'(pending_count), 64'd1);
        check("tp4_rdv3", 64'(bus.m_readdatavalid), 64'b1000);
        step();
        idle();
        mid();
        check("tp4_pend0", 64'(pending_count), 64'd0);
        step();
        // FIFO full: writes still flow, reads wait for a return
        do_reset();
        bus.m_read = 4'b0001;
        repeat (MAXP) begin
            mid();
            step();
        end
        bus.m_write = 4'b0010;
        set_addr(1, 25'h155);
        mid();
        check("tp5_full", 64'(pending_count), 64'd8);
        check("tp5_wr", 64'(bus.s_write), 64'd1);
        check("tp5_rd", 64'(bus.s_read), 64'd0);
        check("tp5_addr", 64'(bus.s_address), 64'h155);
        step();
        bus.m_write = 4'b0000;
        mid();
        check("tp5_blocked", 64'(bus.s_read), 64'd0);
        check("tp5_wait0", 64'(bus.m_waitrequest[0]), 64'd1);
        step();
        bus.s_readdatavalid = 1'b1;
        mid();
        check("tp5_pop_blocks", 64'(bus.s_read), 64'd0);
        step();
        bus.s_readdatavalid = 1'b0;
        mid();
        check("tp5_pend7", 64'(pending_count), 64'd7);
        check("tp5_issue", 64'(bus.s_read), 64'd1);
        step();
        bus.m_read = 4'b0000;
        mid();
        check("tp5_pend8", 64'(pending_count), 64'd8);
        step();
        // orphan return sets sticky flag, reset clears it
        do_reset();
        bus.s_readdatavalid = 1'b1;
        mid();
        check("tp6_no_rdv", 64'(bus.m_readdatavalid), 64'd0);
        step();
        bus.s_readdatavalid = 1'b0;
        mid();
        check("tp6_orphan", 64'(err_orphan), 64'd1);
        step();
        do_reset();
        mid();
        check("tp6_cleared", 64'(err_orphan), 64'd0);
        step();
        // randomized traffic with occasional resets, stalls and orphans
        for (int i = 0; i < 3000; i++) begin
            reset_reset = ($urandom_range(0, 299) == 0);
            bus.m_read = 4'($urandom);
            bus.m_write = 4'($urandom & $urandom & $urandom);
            bus.m_address = (N*AW)'({$urandom, $urandom, $urandom, $urandom});
            bus.m_writedata = (N*DW)'({$urandom, $urandom});
            bus.m_byteenable = 8'($urandom);
            bus.s_waitrequest = ($urandom_range(0, 3) == 0);
            bus.s_readdatavalid = (tags.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            bus.s_readdata = 16'($urandom);
            mid();
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/image_sdram_rr_arbiter.md
Name: image_sdram_rr_arbiter

Overview:
- Parametrised N-master Avalon-MM arbiter placed between the image-processing cores and the single SDRAM controller slave.
- Successor to the single-processor system, where one CPU owns SDRAM; this block lets N_MASTERS cores share the same SDRAM.
- Arbitration is round-robin with a lock held for the life of each command.
- A read-tag FIFO returns pipelined read data to the issuing master.

Parameters:
- N_MASTERS, 4, number of master ports (2..8).
- ADDR_W, 25, word address width toward the SDRAM controller.
- DATA_W, 16, data width; BE_W = DATA_W/8.
- MAX_PENDING, 8, read-tag FIFO depth, i.e. maximum outstanding reads (power of 2).

Ports:
- clk_clk  in  1  system clock; everything is on its rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- m_address  in  N_MASTERS*ADDR_W  packed per-master address; master i occupies slice [i*ADDR_W +: ADDR_W].
- m_read  in  N_MASTERS  per-master read request.
- m_write  in  N_MASTERS  per-master write request.
- m_writedata  in  N_MASTERS*DATA_W  packed write data.
- m_byteenable  in  N_MASTERS*BE_W  packed byte enables.
- m_waitrequest  out  N_MASTERS  per-master stall.
- m_readdata  out  DATA_W  read data, broadcast to all masters.
- m_readdatavalid  out  N_MASTERS  one-hot read return strobe.
- s_address  out  ADDR_W  address to the SDRAM controller.
- s_read  out  1  read to the SDRAM controller.
- s_write  out  1  write to the SDRAM controller.
- s_writedata  out  DATA_W  write data to the SDRAM controller.
- s_byteenable  out  BE_W  byte enables to the SDRAM controller.
- s_waitrequest  in  1  SDRAM controller stall.
- s_readdata  in  DATA_W  SDRAM read data.
- s_readdatavalid  in  1  SDRAM read data valid.
- pending_count  out  log2(MAX_PENDING)+1  number of outstanding reads.
- err_orphan  out  1  sticky flag: read data arrived with no outstanding tag.

Behaviour:
- Reset, while reset_reset=1: lock=0, ptr=0, FIFO empty, pending_count=0, err_orphan=0. While reset is asserted, m_waitrequest is all ones, s_read=s_write=0 and m_readdatavalid=0.
- Request of master i: req[i] = m_write[i] | (m_read[i] & ~full), where full means pending_count==MAX_PENDING.
  - Reads are blocked when full even if a pop occurs in the same cycle.
  - Writes are never blocked by full.
- Selection when unlocked: combinational search of req starting at index ptr and ascending with wrap at N_MASTERS-1 -> 0. The first set bit is the grant g.
  - No request: s_read=s_write=0 and all m_waitrequest=1.
- When locked: g = locked_id, and the selection search is ignored.
- Forwarding: s_* driven from the slice of master g. s_read = m_read[g] & ~m_write[g] & ~full; s_write = m_write[g].
- Simultaneous read and write from one master is illegal. The write is forwarded, no tag is pushed, and the read is dropped.
- m_waitrequest[g] = s_waitrequest. For every other master, m_waitrequest = 1.
- Accept: a command is accepted when (s_read|s_write) & ~s_waitrequest. On accept:
  - ptr <= (g+1) mod N_MASTERS.
  - lock <= 0.
  - If the command is a read, push g into the FIFO.
- Stall: if (s_read|s_write) & s_waitrequest, then lock <= 1 and locked_id <= g. The lock guarantees Avalon address/data stability until acceptance.
- A locked read whose request drops because the FIFO becomes full keeps the lock.
  - s_read stays deasserted and m_waitrequest[g] stays 1 until space frees.
  - This is a deliberate deviation from the normal m_waitrequest[g] = s_waitrequest rule.
- Throughput: one command per cycle when s_waitrequest=0. No bubble on grant change.
- Read return:
  - On s_readdatavalid with the FIFO non-empty: pop head h and m_readdatavalid = one-hot(h) in the same cycle (combinational).
  - m_readdata = s_readdata at all times.
  - Return order equals issue order; the SDRAM controller is in-order.
- Orphan read: on s_readdatavalid with the FIFO empty, err_orphan <= 1 (sticky until reset), m_readdatavalid = 0 and the data is dropped.
- Simultaneous push and pop: allowed. pending_count is unchanged and both pointers advance. The FIFO pointers wrap modulo MAX_PENDING.
- Reset asserted mid-transaction: all state is cleared and outstanding tags are discarded. Returns arriving after reset are orphans and set err_orphan.

Test Plan:
- Single master 0 writes 0xA5A5 to address 0x10 with s_waitrequest=0 -> s_write pulses 1 cycle with s_address=0x10, m_waitrequest[0]=0 that cycle, ptr=1.
- Masters 0..3 all request writes continuously, no stall -> grants issued in order 0,1,2,3,0,... with one command per cycle.
- Master 2 read stalled 3 cycles by s_waitrequest while master 1 requests -> s_address holds master 2's address for all 4 cycles; master 1 is granted on cycle 5.
- Masters 1 then 3 read, returns 0x1111 then 0x3333 -> m_readdatavalid=0b0010 with 0x1111, then 0b1000 with 0x3333; pending_count goes 2,1,0.
- MAX_PENDING=8 reads outstanding, master 0 issues a read and master 1 issues a write -> the write is granted, the read waits, s_read=0. After one return the read issues and pending_count returns to 8.
- s_readdatavalid with pending_count=0 -> err_orphan=1, no m_readdatavalid. Pulse reset_reset -> err_orphan=0.
